// File: rtl/jtgng_cpu_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtgng_cpu_ctrl_pkg : shared constants for the main-CPU control block |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package jtgng_cpu_ctrl_pkg;

  localparam logic [3:0] REG_FLIP  = 4'd0;
  localparam logic [3:0] REG_SRES  = 4'd1;
  localparam logic [3:0] REG_BANK  = 4'd2;
  localparam logic [3:0] REG_SND   = 4'd3;
  localparam logic [3:0] REG_WDOG  = 4'd4;
  localparam logic [3:0] REG_COIN0 = 4'd8;

  localparam logic [15:0] ROM_BANK_BASE = 16'h4000;
  localparam logic [15:0] ROM_FIX_BASE  = 16'h6000;
  localparam int          PAGE_BASE     = 5;

  // Bits needed to hold a down-counter starting at n-1 (never below 1).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtgng_cpu_ctrl_wdog.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtgng_cpu_ctrl_wdog : frame watchdog counter plus reset stretcher   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module jtgng_cpu_ctrl_wdog
  import jtgng_cpu_ctrl_pkg::*;
#(
  parameter int WDW       = 4,
  parameter int WDRST_LEN = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic vb_edge,
  input  logic kick,
  output logic wd_rst
);

  localparam int             PW       = cnt_width(WDRST_LEN);
  localparam logic [WDW-1:0] CNT_MAX  = '1;
  localparam logic [WDW-1:0] CNT_TRIG = CNT_MAX - WDW'(1);

  logic [WDW-1:0] frames;
  logic [PW-1:0]  pulse;

  // While the reset pulse runs the frame counter is frozen; it clears when the pulse ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      frames <= '0;
      pulse  <= '0;
      wd_rst <= 1'b0;
    end else if (wd_rst) begin
      if (pulse == '0) begin
        wd_rst <= 1'b0;
        frames <= '0;
      end else begin
        pulse <= pulse - PW'(1);
      end
    end else if (kick) begin
      frames <= '0;
    end else if (vb_edge) begin
      frames <= frames + WDW'(1);
      if (frames == CNT_TRIG) begin
        wd_rst <= 1'b1;
        pulse  <= PW'(WDRST_LEN - 1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/jtgng_cpu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtgng_cpu_ctrl : main-CPU registers, ROM banking, IRQ, sound latch  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module jtgng_cpu_ctrl
  import jtgng_cpu_ctrl_pkg::*;
#(
  parameter int BANKW     = 3,
  parameter int BANKS     = 5,
  parameter int ROMW      = 17,
  parameter int NCOIN     = 2,
  parameter int COINW     = 4,
  parameter int WDW       = 4,
  parameter int WDRST_LEN = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  input  logic [15:0]            cpu_addr,
  input  logic [7:0]             cpu_dout,
  input  logic                   cpu_rnw,
  input  logic                   ctrl_cs,
  input  logic                   rom_cs,
  input  logic                   rom_ok,
  input  logic                   LVBL,
  input  logic                   irq_ack,
  input  logic                   snd_rd,
  output logic                   cpu_cen,
  output logic [ROMW-1:0]        rom_addr,
  output logic                   nirq,
  output logic [BANKW-1:0]       bank,
  output logic                   flip,
  output logic                   sres_b,
  output logic [7:0]             snd_latch,
  output logic                   snd_full,
  output logic [NCOIN*COINW-1:0] coin_cnt,
  output logic                   wd_rst
);

  localparam int PAGEW = ROMW - 13;

  logic       wr_acc, wr_l, wr_act, lvbl_l, vb_edge;
  logic [3:0] reg_sel;

  // Only the first cen of a write access acts, however long ctrl_cs is held.
  assign wr_acc  = ctrl_cs & ~cpu_rnw;
  assign wr_act  = cen & wr_acc & ~wr_l;
  assign reg_sel = cpu_addr[3:0];
  assign vb_edge = cen & lvbl_l & ~LVBL;
  assign cpu_cen = cen & ~(rom_cs & ~rom_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_l   <= 1'b0;
      lvbl_l <= 1'b0;
    end else if (cen) begin
      wr_l   <= wr_acc;
      lvbl_l <= LVBL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flip      <= 1'b0;
      sres_b    <= 1'b1;
      bank      <= '0;
      snd_latch <= '0;
      snd_full  <= 1'b0;
    end else begin
      if (snd_rd) snd_full <= 1'b0;
      if (wr_act) begin
        case (reg_sel)
          REG_FLIP: flip   <= cpu_dout[0];
          REG_SRES: sres_b <= cpu_dout[0];
          REG_BANK: bank   <= cpu_dout[BANKW-1:0];
          REG_SND: begin
            snd_latch <= cpu_dout;
            snd_full  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // A new vblank edge overrides a simultaneous acknowledge.
  always_ff @(posedge clk) begin
    if (rst)                nirq <= 1'b1;
    else if (vb_edge)       nirq <= 1'b0;
    else if (cen & irq_ack) nirq <= 1'b1;
  end

  for (genvar i = 0; i < NCOIN; i++) begin : g_coin
    logic [COINW-1:0] cnt;
    always_ff @(posedge clk) begin
      if (rst)
        cnt <= '0;
      else if (wr_act && reg_sel == REG_COIN0 + 4'(i))
        cnt <= cnt + COINW'(cpu_dout[0]);
    end
    assign coin_cnt[i*COINW +: COINW] = cnt;
  end

  logic [PAGEW-1:0] page;
  logic [15:0]      fix_off;

  always_comb begin
    page = PAGEW'(PAGE_BASE);
    if (32'(bank) < BANKS) page = PAGEW'(PAGE_BASE) + PAGEW'(bank);
    fix_off  = cpu_addr - ROM_FIX_BASE;
    rom_addr = '0;
    if (cpu_addr >= ROM_FIX_BASE)       rom_addr = ROMW'(fix_off);
    else if (cpu_addr >= ROM_BANK_BASE) rom_addr = {page, cpu_addr[12:0]};
  end

  if (WDW > 0) begin : g_wdog
    jtgng_cpu_ctrl_wdog #(
      .WDW       (WDW),
      .WDRST_LEN (WDRST_LEN)
    ) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .vb_edge (vb_edge),
      .kick    (wr_act && reg_sel == REG_WDOG),
      .wd_rst  (wd_rst)
    );
  end else begin : g_no_wdog
    assign wd_rst = 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_jtgng_cpu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_jtgng_cpu_ctrl : directed self-checking bench, default params    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_jtgng_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst, cen, cpu_rnw, ctrl_cs, rom_cs, rom_ok, LVBL, irq_ack, snd_rd;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_cen, nirq, flip, sres_b, snd_full, wd_rst;
  logic [16:0] rom_addr;
  logic [2:0]  bank;
  logic [7:0]  snd_latch;
  logic [7:0]  coin_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int wd_hi = 0;

  always #5 clk = ~clk;
  always @(negedge clk) if (wd_rst) wd_hi++;

  jtgng_cpu_ctrl dut (
    .clk(clk), .rst(rst), .cen(cen), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_rnw(cpu_rnw), .ctrl_cs(ctrl_cs), .rom_cs(rom_cs), .rom_ok(rom_ok),
    .LVBL(LVBL), .irq_ack(irq_ack), .snd_rd(snd_rd), .cpu_cen(cpu_cen),
    .rom_addr(rom_addr), .nirq(nirq), .bank(bank), .flip(flip), .sres_b(sres_b),
    .snd_latch(snd_latch), .snd_full(snd_full), .coin_cnt(coin_cnt), .wd_rst(wd_rst)
  );

  task automatic wr(input logic [3:0] off, input logic [7:0] d);
    @(negedge clk);
    cpu_addr = {12'h000, off};
    cpu_dout = d;
    ctrl_cs  = 1'b1;
    cpu_rnw  = 1'b0;
    @(negedge clk);
    ctrl_cs  = 1'b0;
    cpu_rnw  = 1'b1;
  endtask

  task automatic frame();
    @(negedge clk) LVBL = 1'b0;
    @(negedge clk) LVBL = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    n_cmp++; if (bank !== 3'd0)      begin n_err++; $display("FAIL %s bank: got %h want 0", tag, bank); end
    n_cmp++; if (flip !== 1'b0)      begin n_err++; $display("FAIL %s flip: got %b want 0", tag, flip); end
    n_cmp++; if (sres_b !== 1'b1)    begin n_err++; $display("FAIL %s sres_b: got %b want 1", tag, sres_b); end
    n_cmp++; if (snd_latch !== 8'h0) begin n_err++; $display("FAIL %s snd_latch: got %h want 00", tag, snd_latch); end
    n_cmp++; if (snd_full !== 1'b0)  begin n_err++; $display("FAIL %s snd_full: got %b want 0", tag, snd_full); end
    n_cmp++; if (coin_cnt !== 8'h0)  begin n_err++; $display("FAIL %s coin_cnt: got %h want 00", tag, coin_cnt); end
    n_cmp++; if (nirq !== 1'b1)      begin n_err++; $display("FAIL %s nirq: got %b want 1", tag, nirq); end
    n_cmp++; if (wd_rst !== 1'b0)    begin n_err++; $display("FAIL %s wd_rst: got %b want 0", tag, wd_rst); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_bank_rom();
    wr(4'd2, 8'h03);
    cpu_addr = 16'h4123; #1;
    n_cmp++; if (bank !== 3'd3) begin n_err++; $display("FAIL bank_reg: got %h want 3", bank); end
    n_cmp++; if (rom_addr !== 17'h10123) begin n_err++; $display("FAIL rom_bank3: got %h want 10123", rom_addr); end
    wr(4'd2, 8'h04);
    cpu_addr = 16'h5FFF; #1;
    n_cmp++; if (rom_addr !== 17'h13FFF) begin n_err++; $display("FAIL rom_bank4: got %h want 13fff", rom_addr); end
    wr(4'd2, 8'h05);
    cpu_addr = 16'h4123; #1;
    n_cmp++; if (rom_addr !== 17'h0A123) begin n_err++; $display("FAIL rom_bank5: got %h want 0a123", rom_addr); end
    wr(4'd2, 8'h06);
    cpu_addr = 16'h4123; #1;
    n_cmp++; if (rom_addr !== 17'h0A123) begin n_err++; $display("FAIL rom_bank6: got %h want 0a123", rom_addr); end
    cpu_addr = 16'h6000; #1;
    n_cmp++; if (rom_addr !== 17'h00000) begin n_err++; $display("FAIL rom_fix_lo: got %h want 00000", rom_addr); end
    cpu_addr = 16'hFFFF; #1;
    n_cmp++; if (rom_addr !== 17'h09FFF) begin n_err++; $display("FAIL rom_fix_hi: got %h want 09fff", rom_addr); end
    cpu_addr = 16'h3FFF; #1;
    n_cmp++; if (rom_addr !== 17'h00000) begin n_err++; $display("FAIL rom_low: got %h want 00000", rom_addr); end
  endtask

  task automatic test_flip_sres();
    wr(4'd0, 8'h01);
    n_cmp++; if (flip !== 1'b1) begin n_err++; $display("FAIL flip_set: got %b want 1", flip); end
    wr(4'd1, 8'hFE);
    n_cmp++; if (sres_b !== 1'b0) begin n_err++; $display("FAIL sres_clr: got %b want 0", sres_b); end
    wr(4'd1, 8'h01);
    n_cmp++; if (sres_b !== 1'b1) begin n_err++; $display("FAIL sres_set: got %b want 1", sres_b); end
  endtask

  task automatic test_coin();
    @(negedge clk);
    cpu_addr = 16'h0009; cpu_dout = 8'h01; ctrl_cs = 1'b1; cpu_rnw = 1'b0;
    repeat (3) @(negedge clk);
    ctrl_cs = 1'b0; cpu_rnw = 1'b1;
    n_cmp++; if (coin_cnt !== 8'h10) begin n_err++; $display("FAIL coin_hold: got %h want 10", coin_cnt); end
    for (int i = 0; i < 14; i++) wr(4'd9, 8'h01);
    wr(4'd9, 8'h00);
    wr(4'd10, 8'h01);
    n_cmp++; if (coin_cnt !== 8'hF0) begin n_err++; $display("FAIL coin_15: got %h want f0", coin_cnt); end
    wr(4'd9, 8'h01);
    n_cmp++; if (coin_cnt !== 8'h00) begin n_err++; $display("FAIL coin_wrap: got %h want 00", coin_cnt); end
    wr(4'd8, 8'h01);
    wr(4'd8, 8'hFF);
    n_cmp++; if (coin_cnt !== 8'h02) begin n_err++; $display("FAIL coin_ch0: got %h want 02", coin_cnt); end
  endtask

  task automatic test_snd();
    wr(4'd3, 8'h5A);
    n_cmp++; if (snd_latch !== 8'h5A) begin n_err++; $display("FAIL snd_latch: got %h want 5a", snd_latch); end
    n_cmp++; if (snd_full !== 1'b1) begin n_err++; $display("FAIL snd_full_set: got %b want 1", snd_full); end
    @(negedge clk);
    cpu_addr = 16'h0003; cpu_dout = 8'h11; ctrl_cs = 1'b1; cpu_rnw = 1'b0; snd_rd = 1'b1;
    @(negedge clk);
    ctrl_cs = 1'b0; cpu_rnw = 1'b1; snd_rd = 1'b0;
    n_cmp++; if (snd_full !== 1'b1) begin n_err++; $display("FAIL snd_wr_vs_rd: got %b want 1", snd_full); end
    n_cmp++; if (snd_latch !== 8'h11) begin n_err++; $display("FAIL snd_overwrite: got %h want 11", snd_latch); end
    snd_rd = 1'b1;
    @(negedge clk) snd_rd = 1'b0;
    n_cmp++; if (snd_full !== 1'b0) begin n_err++; $display("FAIL snd_rd_clr: got %b want 0", snd_full); end
  endtask

  task automatic test_irq();
    n_cmp++; if (nirq !== 1'b1) begin n_err++; $display("FAIL irq_idle: got %b want 1", nirq); end
    @(negedge clk) LVBL = 1'b0;
    @(negedge clk) LVBL = 1'b1;
    n_cmp++; if (nirq !== 1'b0) begin n_err++; $display("FAIL irq_edge: got %b want 0", nirq); end
    @(negedge clk) begin cen = 1'b0; irq_ack = 1'b1; end
    @(negedge clk) begin cen = 1'b1; irq_ack = 1'b0; end
    n_cmp++; if (nirq !== 1'b0) begin n_err++; $display("FAIL irq_ack_nocen: got %b want 0", nirq); end
    LVBL = 1'b0; irq_ack = 1'b1;
    @(negedge clk) begin LVBL = 1'b1; irq_ack = 1'b0; end
    n_cmp++; if (nirq !== 1'b0) begin n_err++; $display("FAIL irq_edge_vs_ack: got %b want 0", nirq); end
    @(negedge clk) irq_ack = 1'b1;
    @(negedge clk) irq_ack = 1'b0;
    n_cmp++; if (nirq !== 1'b1) begin n_err++; $display("FAIL irq_lone_ack: got %b want 1", nirq); end
  endtask

  task automatic test_wdog();
    int base, hi;
    wr(4'd4, 8'h00);
    base = wd_hi;
    for (int i = 0; i < 14; i++) frame();
    n_cmp++; if (wd_hi != base) begin n_err++; $display("FAIL wdog_14: got %0d high cycles want 0", wd_hi - base); end
    @(negedge clk) LVBL = 1'b0;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk) LVBL = 1'b1;
      if (wd_rst) hi++;
    end
    n_cmp++; if (hi != 16) begin n_err++; $display("FAIL wdog_pulse_len: got %0d want 16", hi); end
    base = wd_hi;
    for (int i = 0; i < 14; i++) frame();
    n_cmp++; if (wd_hi != base) begin n_err++; $display("FAIL wdog_cleared: got %0d high cycles want 0", wd_hi - base); end
    for (int i = 0; i < 20; i++) begin
      wr(4'd4, 8'h00);
      frame();
    end
    n_cmp++; if (wd_hi != base) begin n_err++; $display("FAIL wdog_kicked: got %0d high cycles want 0", wd_hi - base); end
  endtask

  task automatic test_reset_mid();
    int base;
    wr(4'd0, 8'h01);
    wr(4'd2, 8'h05);
    wr(4'd3, 8'hC3);
    wr(4'd8, 8'h01);
    wr(4'd1, 8'h00);
    wr(4'd4, 8'h00);
    for (int i = 0; i < 15; i++) frame();
    repeat (3) @(negedge clk);
    n_cmp++; if (wd_rst !== 1'b1) begin n_err++; $display("FAIL mid_pulse_active: got %b want 1", wd_rst); end
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_reset_values("mid_reset");
    base = wd_hi;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 14; i++) frame();
    n_cmp++; if (wd_hi != base) begin n_err++; $display("FAIL mid_wdog_cnt: got %0d high cycles want 0", wd_hi - base); end
  endtask

  task automatic test_stall();
    int lo;
    lo = 0;
    @(negedge clk) begin rom_cs = 1'b1; rom_ok = 1'b0; cen = 1'b1; end
    for (int i = 0; i < 5; i++) begin
      #1 if (!cpu_cen) lo++;
      @(negedge clk);
    end
    n_cmp++; if (lo != 5) begin n_err++; $display("FAIL stall_cycles: got %0d want 5", lo); end
    rom_ok = 1'b1; #1;
    n_cmp++; if (cpu_cen !== 1'b1) begin n_err++; $display("FAIL stall_release: got %b want 1", cpu_cen); end
    cen = 1'b0; #1;
    n_cmp++; if (cpu_cen !== 1'b0) begin n_err++; $display("FAIL cen_off: got %b want 0", cpu_cen); end
    cen = 1'b1; rom_cs = 1'b0; rom_ok = 1'b0; #1;
    n_cmp++; if (cpu_cen !== 1'b1) begin n_err++; $display("FAIL no_rom_cs: got %b want 1", cpu_cen); end
  endtask

  initial begin
    rst = 1'b1; cen = 1'b1; cpu_rnw = 1'b1; ctrl_cs = 1'b0; rom_cs = 1'b0; rom_ok = 1'b0;
    LVBL = 1'b1; irq_ack = 1'b0; snd_rd = 1'b0; cpu_addr = 16'h0; cpu_dout = 8'h0;
    test_reset();
    test_bank_rom();
    test_flip_sres();
    test_coin();
    test_snd();
    test_irq();
    test_wdog();
    test_reset_mid();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
